// File: rtl/irq_sequencer.sv
// Interrupt sequencer: filters PIC requests, masks them against the CPU level and
// the in-service stack, and presents one held request (maskable or NMI) with its vector.
module irq_sequencer #(
  parameter int          pStable   = 2,
  parameter int          pDepth    = 4,
  parameter logic [31:0] pVecBase  = 32'hFFFC_0000,
  parameter logic [7:0]  pNmiCause = 8'hFE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  irq_i,
  input  logic [7:0]  cause_i,
  input  logic        nmi_i,
  input  logic [3:0]  im_i,
  input  logic        ack_i,
  input  logic        eoi_i,
  output logic        irq_req_o,
  output logic        nmi_req_o,
  output logic [3:0]  level_o,
  output logic [7:0]  cause_o,
  output logic [31:0] vector_o,
  output logic [2:0]  depth_o,
  output logic        ovf_o,
  output logic        err_o
);

  localparam int CW = (pStable < 2) ? 1 : $clog2(pStable + 1);
  localparam int AW = (pDepth < 2) ? 1 : $clog2(pDepth);
  localparam logic [CW-1:0] STABLE_CNT = CW'(pStable);
  localparam logic [2:0]    FULL_DEPTH = 3'(pDepth);
  localparam logic [AW-1:0] TOP_SLOT   = AW'(pDepth - 1);

  typedef enum logic [1:0] {IDLE, IRQ_PEND, NMI_PEND} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [3:0]    r_irq;
  logic [7:0]    r_cause;
  logic [CW-1:0] r_cnt;
  logic          r_nmi_d;
  logic          r_nmi_pend;

  logic [3:0]    r_stack [pDepth];
  logic [2:0]    r_depth;
  logic          r_ovf;
  logic          r_err;

  logic          r_irq_req;
  logic          r_nmi_req;
  logic [3:0]    r_level;
  logic [7:0]    r_cause_out;
  logic [31:0]   r_vector;

  logic          w_irq_req_next;
  logic          w_nmi_req_next;
  logic [3:0]    w_level_next;
  logic [7:0]    w_cause_next;
  logic [31:0]   w_vector_next;

  logic          w_candidate;
  logic [3:0]    w_top;
  logic [3:0]    w_em;
  logic          w_eligible;
  logic          w_nmi_rise;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_push_lvl;
  logic [2:0]    w_depth_pop;
  logic          w_full_after_pop;
  logic [AW-1:0] w_wr_idx;

  // Input stage: a level/cause pair only counts once it has held for pStable samples.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_irq   <= '0;
      r_cause <= '0;
      r_cnt   <= '0;
      r_nmi_d <= 1'b0;
    end else begin
      r_irq   <= irq_i;
      r_cause <= cause_i;
      r_nmi_d <= nmi_i;
      if (irq_i == 4'd0 || {irq_i, cause_i} != {r_irq, r_cause})
        r_cnt <= CW'(1);
      else if (r_cnt < STABLE_CNT)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_candidate = (r_irq != 4'd0) && (r_cnt == STABLE_CNT);
  assign w_top       = (r_depth != 3'd0) ? r_stack[AW'(r_depth - 3'd1)] : 4'd0;
  assign w_em        = (r_depth != 3'd0 && w_top > im_i) ? w_top : im_i;
  assign w_eligible  = w_candidate && (r_irq > w_em) && (r_depth < FULL_DEPTH);
  assign w_nmi_rise  = nmi_i && !r_nmi_d;

  // A new NMI edge wins over the clear so a back-to-back NMI is never lost.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_nmi_pend <= 1'b0;
    else if (w_nmi_rise)
      r_nmi_pend <= 1'b1;
    else if (r_state == NMI_PEND && ack_i)
      r_nmi_pend <= 1'b0;
  end

  // Nesting stack: an eoi pops first, then an ack pushes into whatever room remains.
  assign w_push           = ack_i && (r_state != IDLE);
  assign w_pop            = eoi_i && (r_depth != 3'd0);
  assign w_push_lvl       = (r_state == NMI_PEND) ? 4'hF : r_level;
  assign w_depth_pop      = r_depth - {2'b00, w_pop};
  assign w_full_after_pop = (w_depth_pop == FULL_DEPTH);
  assign w_wr_idx         = w_full_after_pop ? TOP_SLOT : AW'(w_depth_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < pDepth; i++)
        r_stack[i] <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= eoi_i && (r_depth == 3'd0);
      if (w_push) begin
        r_stack[w_wr_idx] <= w_push_lvl;
        r_depth <= w_full_after_pop ? w_depth_pop : w_depth_pop + 3'd1;
        if (w_full_after_pop && r_state == NMI_PEND)
          r_ovf <= 1'b1;
      end else begin
        r_depth <= w_depth_pop;
      end
    end
  end

  // State and presented-request registers change on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_irq_req   <= 1'b0;
      r_nmi_req   <= 1'b0;
      r_level     <= '0;
      r_cause_out <= '0;
      r_vector    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_irq_req   <= w_irq_req_next;
      r_nmi_req   <= w_nmi_req_next;
      r_level     <= w_level_next;
      r_cause_out <= w_cause_next;
      r_vector    <= w_vector_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_nmi_pend)
          w_next_state = NMI_PEND;
        else if (w_eligible)
          w_next_state = IRQ_PEND;
      end
      IRQ_PEND: begin
        if (ack_i)
          w_next_state = IDLE;
        else if (r_nmi_pend)
          w_next_state = NMI_PEND;
        else if (!w_eligible)
          w_next_state = IDLE;
      end
      NMI_PEND: begin
        if (ack_i)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A maskable request keeps its latched level/cause for as long as it is presented.
  always_comb begin
    w_irq_req_next = 1'b0;
    w_nmi_req_next = 1'b0;
    w_level_next   = '0;
    w_cause_next   = '0;
    case (w_next_state)
      IRQ_PEND: begin
        w_irq_req_next = 1'b1;
        if (r_state == IRQ_PEND) begin
          w_level_next = r_level;
          w_cause_next = r_cause_out;
        end else begin
          w_level_next = r_irq;
          w_cause_next = r_cause;
        end
      end
      NMI_PEND: begin
        w_nmi_req_next = 1'b1;
        w_level_next   = 4'hF;
        w_cause_next   = pNmiCause;
      end
      default: ;
    endcase
    w_vector_next = (w_next_state == IDLE) ? 32'd0
                                           : pVecBase + {20'd0, w_cause_next, 4'd0};
  end

  assign irq_req_o = r_irq_req;
  assign nmi_req_o = r_nmi_req;
  assign level_o   = r_level;
  assign cause_o   = r_cause_out;
  assign vector_o  = r_vector;
  assign depth_o   = r_depth;
  assign ovf_o     = r_ovf;
  assign err_o     = r_err;

endmodule
